// File: rtl/ram_responder_if.sv
// Request/response bundle between the datapath and the data-memory responder.
// Under RAM_WSTRB_EN the request also carries per-byte write strobes.
interface ram_responder_if #(
    parameter int BITS = 63
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BITS:0]     req_addr;
    logic [BITS:0]     req_wdata;
`ifdef RAM_WSTRB_EN
    logic [(BITS+1)/8-1:0] req_wstrb;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [BITS:0]     rsp_rdata;
    logic              rsp_err;

    modport master (
`ifdef RAM_WSTRB_EN
        output req_wstrb,
`endif
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
`ifdef RAM_WSTRB_EN
        input  req_wstrb,
`endif
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, fixed LATENCY.
// Optional byte-strobed stores when RAM_WSTRB_EN is defined.
module ram_responder #(
    parameter int BITS    = 63,
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    ram_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = (BITS + 1) / 8;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BITS:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            req_we_q, req_we_d;
    logic [BITS:0]   req_addr_q, req_addr_d;
    logic [BITS:0]   req_wdata_q, req_wdata_d;
`ifdef RAM_WSTRB_EN
    logic [NB-1:0]   req_wstrb_q, req_wstrb_d;
`endif

    logic [BITS:0]   mem_q [DEPTH] = '{default: '0};

    logic            accept;
    logic            commit;
    logic            cur_we;
    logic [BITS:0]   cur_addr;
    logic [BITS:0]   cur_wdata;
    logic [NB-1:0]   cur_wstrb;
    logic [ADDR_W-1:0] idx;
    logic            addr_err;
    logic [BITS:0]   old_word;
    logic            mem_we;
    logic [BITS:0]   mem_wdata;

    // With LATENCY=1 the access commits on the accepting edge itself, so the
    // live request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        accept      = (state_q == IDLE) && bus.req_valid;
        cur_we      = (state_q == IDLE) ? bus.req_we    : req_we_q;
        cur_addr    = (state_q == IDLE) ? bus.req_addr  : req_addr_q;
        cur_wdata   = (state_q == IDLE) ? bus.req_wdata : req_wdata_q;
`ifdef RAM_WSTRB_EN
        cur_wstrb   = (state_q == IDLE) ? bus.req_wstrb : req_wstrb_q;
        req_wstrb_d = accept ? bus.req_wstrb : req_wstrb_q;
`else
        cur_wstrb   = '1;
`endif
        req_we_d    = accept ? bus.req_we    : req_we_q;
        req_addr_d  = accept ? bus.req_addr  : req_addr_q;
        req_wdata_d = accept ? bus.req_wdata : req_wdata_q;

        idx      = cur_addr[ADDR_W+2:3];
        addr_err = (|cur_addr[2:0]) || (|cur_addr[BITS:ADDR_W+3]);
        old_word = mem_q[idx];
        commit   = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd0));

        for (int b = 0; b < NB; b++) begin
            mem_wdata[b*8 +: 8] = cur_wstrb[b] ? cur_wdata[b*8 +: 8] : old_word[b*8 +: 8];
        end
        mem_we = commit && cur_we && !addr_err && reset;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rsp_err_d   = addr_err;
            rsp_rdata_d = (cur_we || addr_err) ? '0 : old_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request payload and array contents are data only and survive reset.
    always_ff @(posedge clk) begin
        req_we_q    <= req_we_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
`ifdef RAM_WSTRB_EN
        req_wstrb_q <= req_wstrb_d;
`endif
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder against a word-array reference model.
module tb_ram_responder;
    localparam int BITS    = 63;
    localparam int ADDR_W  = 6;
    localparam int LATENCY = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ram_responder_if #(.BITS(BITS)) bus ();

    ram_responder #(
        .BITS    (BITS),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [63:0] mem_m [1 << ADDR_W];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic addr_is_err(input logic [63:0] a);
        return (a[2:0] != 3'd0) || ((a >> (ADDR_W + 3)) != 64'd0);
    endfunction

    task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [7:0] strb, input int hold);
        logic        err;
        logic [63:0] exp_rd;
        int          idx;
        int          lat;
        err    = addr_is_err(addr);
        idx    = int'(addr[ADDR_W+2:3]);
        exp_rd = (we || err) ? 64'd0 : mem_m[idx];
        if (we && !err) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mem_m[idx][b*8 +: 8] = wd[b*8 +: 8];
            end
        end

        @(negedge clk);
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
`ifdef RAM_WSTRB_EN
        bus.req_wstrb = strb;
`endif
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = {$urandom, $urandom};
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            check("req_ready_busy", 64'(bus.req_ready), 64'd0);
            bus.rsp_ready = 1'($urandom % 2);
            @(negedge clk);
            lat++;
        end
        bus.rsp_ready = 1'b0;
        check("latency", 64'(lat), 64'(LATENCY));
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_err", 64'(bus.rsp_err), 64'(err));
        check("rsp_rdata", bus.rsp_rdata, exp_rd);

        repeat (hold) begin
            bus.req_valid = 1'($urandom % 2);
            bus.req_we    = 1'b1;
            @(negedge clk);
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_rdata", bus.rsp_rdata, exp_rd);
            check("hold_err", 64'(bus.rsp_err), 64'(err));
            check("hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("done_valid", 64'(bus.rsp_valid), 64'd0);
        check("done_rdata", bus.rsp_rdata, 64'd0);
        check("done_err", 64'(bus.rsp_err), 64'd0);
        check("done_ready", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [7:0]  s;
        int          kind;
        int          idx;
        for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = 64'd0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 64'd0;
        bus.req_wdata = 64'd0;
        bus.rsp_ready = 1'b0;
`ifdef RAM_WSTRB_EN
        bus.req_wstrb = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);

        txn(1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF, 0);
        txn(1'b0, 64'h10, 64'd0, 8'hFF, 0);
        txn(1'b0, 64'h10, 64'd0, 8'hFF, 5);
        txn(1'b1, 64'h13, 64'hDEADBEEFDEADBEEF, 8'hFF, 1);
        txn(1'b0, 64'h10, 64'd0, 8'hFF, 0);
        txn(1'b0, 64'h200, 64'd0, 8'hFF, 0);

        // Store to 0x18 interrupted by reset while still counting down.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 64'h18;
        bus.req_wdata = 64'hFF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_rdata", bus.rsp_rdata, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_after", 64'(bus.rsp_valid), 64'd0);
        txn(1'b0, 64'h18, 64'd0, 8'hFF, 0);

`ifdef RAM_WSTRB_EN
        txn(1'b1, 64'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0);
        txn(1'b1, 64'h20, 64'd0, 8'h0F, 0);
        txn(1'b0, 64'h20, 64'd0, 8'hFF, 0);
        check("strb_model", mem_m[4], 64'hFFFFFFFF00000000);
        txn(1'b1, 64'h20, 64'd0, 8'h00, 0);
        txn(1'b0, 64'h20, 64'd0, 8'hFF, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            idx  = (kind == 9) ? $urandom_range(0, 63) : $urandom_range(0, 7);
            a    = 64'(idx) << 3;
            if (kind == 0) a = a | 64'($urandom_range(1, 7));
            if (kind == 1) a = a | (64'd1 << $urandom_range(9, 63));
`ifdef RAM_WSTRB_EN
            s = 8'($urandom);
`else
            s = 8'hFF;
`endif
            txn(1'($urandom % 2), a, {$urandom, $urandom}, s, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
